// File: rtl/opt_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : opt_gen_if
//  Description : Proposal handshake bundle between a move-proposal generator
//                (master) and the replica node sequencer that consumes it
//                (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface opt_gen_if #(
    parameter int CITY_NUM_LOG = 5
) ();
    logic                    opt_req;
    logic                    opt_ready;
    logic                    opt_valid;
    logic                    opt_mode;
    logic [CITY_NUM_LOG-1:0] opt_k;
    logic [CITY_NUM_LOG-1:0] opt_l;
    logic                    busy;

    // Generator side: takes requests, presents proposals.
    modport master (
        input  opt_req,
        input  opt_ready,
        output opt_valid,
        output opt_mode,
        output opt_k,
        output opt_l,
        output busy
    );

    // Consumer side: issues requests, accepts proposals.
    modport slave (
        output opt_req,
        output opt_ready,
        input  opt_valid,
        input  opt_mode,
        input  opt_k,
        input  opt_l,
        input  busy
    );
endinterface
`default_nettype wire

// File: rtl/opt_gen.sv
`default_nettype none
// ============================================================================
//  Module      : opt_gen
//  Description : Per-replica move-proposal generator. Owns an xorshift64
//                state and draws a random 2-opt / or-opt move with two city
//                positions, presented under a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module opt_gen #(
    parameter int ID           = 0,
    parameter int CITY_NUM     = 30,
    parameter int CITY_NUM_LOG = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        random_init,
    input  logic [63:0] random_seed,
    opt_gen_if.master   bus
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DRAW_K = 2'd1;
    localparam logic [1:0] S_DRAW_L = 2'd2;
    localparam logic [1:0] S_OUT    = 2'd3;

    // Golden-ratio multiplier spreads the per-replica seed offsets apart.
    localparam logic [63:0]             c_golden   = 64'h9E3779B97F4A7C15;
    localparam logic [63:0]             c_seed_mix = c_golden * 64'(ID + 1);
    localparam logic [CITY_NUM_LOG-1:0] c_max_pos  = CITY_NUM_LOG'(CITY_NUM - 1);
    localparam logic [CITY_NUM_LOG-1:0] c_one      = CITY_NUM_LOG'(1);

    logic [63:0]             r_x;
    logic [1:0]              r_state;
    logic                    r_busy;
    logic                    r_valid;
    logic                    r_mode;
    logic [CITY_NUM_LOG-1:0] r_k;
    logic [CITY_NUM_LOG-1:0] r_l;
    logic [CITY_NUM_LOG-1:0] r_k_draw;
    logic                    r_mode_draw;

    logic [63:0]             w_step;
    logic [63:0]             w_seed_mix;
    logic [63:0]             w_seed_load;
    logic [CITY_NUM_LOG-1:0] w_cand;
    logic [CITY_NUM_LOG-1:0] w_k_minus1;
    logic                    w_cand_legal;
    logic                    w_l_accept;
    logic [CITY_NUM_LOG-1:0] w_out_k;
    logic [CITY_NUM_LOG-1:0] w_out_l;
    logic [1:0]              w_state_next;
    logic [63:0]             w_x_next;
    logic                    w_latch_k;
    logic                    w_enter_out;

    function automatic logic [63:0] xorshift_step(input logic [63:0] x);
        logic [63:0] a;
        logic [63:0] b;
        a = x ^ (x << 13);
        b = a ^ (a >> 7);
        return b ^ (b << 17);
    endfunction

    // Candidate draw, acceptance rules and the seed derived from the global seed.
    always_comb begin
        w_step       = xorshift_step(r_x);
        w_cand       = w_step[CITY_NUM_LOG-1:0];
        w_k_minus1   = r_k_draw - c_one;
        // Position 0 is the fixed start city and out-of-range indices are rejected.
        w_cand_legal = (w_cand != '0) && (w_cand <= c_max_pos);
        // 2-opt needs two distinct positions; or-opt additionally must not
        // re-insert the city right where it already sits (after k-1).
        w_l_accept   = w_cand_legal && (w_cand != r_k_draw) &&
                       (r_mode_draw || (w_cand != w_k_minus1));
        if (r_mode_draw) begin
            w_out_k = (w_cand < r_k_draw) ? w_cand : r_k_draw;
            w_out_l = (w_cand < r_k_draw) ? r_k_draw : w_cand;
        end else begin
            w_out_k = r_k_draw;
            w_out_l = w_cand;
        end
        w_seed_mix   = random_seed ^ c_seed_mix;
        // An all-zero state would lock xorshift at zero forever.
        w_seed_load  = (w_seed_mix == 64'd0) ? 64'd1 : w_seed_mix;
    end

    // Next-state logic; the random state only moves while drawing.
    always_comb begin
        w_state_next = r_state;
        w_x_next     = r_x;
        w_latch_k    = 1'b0;
        w_enter_out  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.opt_req) begin
                    w_state_next = S_DRAW_K;
                end
            end
            S_DRAW_K: begin
                w_x_next = w_step;
                if (w_cand_legal) begin
                    w_latch_k    = 1'b1;
                    w_state_next = S_DRAW_L;
                end
            end
            S_DRAW_L: begin
                w_x_next = w_step;
                if (w_l_accept) begin
                    w_enter_out  = 1'b1;
                    w_state_next = S_OUT;
                end
            end
            S_OUT: begin
                if (bus.opt_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State, random state and output registers; reseed overrides any activity.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_x         <= 64'd1;
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_valid     <= 1'b0;
            r_mode      <= 1'b0;
            r_k         <= '0;
            r_l         <= '0;
            r_k_draw    <= '0;
            r_mode_draw <= 1'b0;
        end else if (random_init) begin
            r_x     <= w_seed_load;
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_x     <= w_x_next;
            r_state <= w_state_next;
            r_busy  <= (w_state_next != S_IDLE);
            r_valid <= (w_state_next == S_OUT);
            if (w_latch_k) begin
                r_k_draw    <= w_cand;
                r_mode_draw <= w_step[63];
            end
            if (w_enter_out) begin
                r_mode <= r_mode_draw;
                r_k    <= w_out_k;
                r_l    <= w_out_l;
            end
        end
    end

    assign bus.opt_valid = r_valid;
    assign bus.opt_mode  = r_mode;
    assign bus.opt_k     = r_k;
    assign bus.opt_l     = r_l;
    assign bus.busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_opt_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_opt_gen
//  Description : Self-checking bench for opt_gen. Two instances (30 cities
//                and 17 cities) are driven with random requests; expected
//                proposals come from a reference model and are queued for a
//                monitor that compares on every presented proposal.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_opt_gen;
    localparam int LOG  = 5;
    localparam int N_A  = 30;
    localparam int N_B  = 17;
    localparam int ID_A = 0;
    localparam int ID_B = 3;

    typedef struct packed {
        logic           mode;
        logic [LOG-1:0] k;
        logic [LOG-1:0] l;
        int             lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        init_a, init_b;
    logic [63:0] seed_a, seed_b;

    opt_gen_if #(.CITY_NUM_LOG(LOG)) bus_a ();
    opt_gen_if #(.CITY_NUM_LOG(LOG)) bus_b ();

    opt_gen #(.ID(ID_A), .CITY_NUM(N_A), .CITY_NUM_LOG(LOG)) dut_a (
        .clk(clk), .reset(reset), .random_init(init_a), .random_seed(seed_a), .bus(bus_a)
    );
    opt_gen #(.ID(ID_B), .CITY_NUM(N_B), .CITY_NUM_LOG(LOG)) dut_b (
        .clk(clk), .reset(reset), .random_init(init_b), .random_seed(seed_b), .bus(bus_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          errors = 0;
    int          checks = 0;
    int          hs_cnt [2];
    int          req_edge [2];
    logic        prev_valid [2];
    logic        hs_prev [2];
    logic [63:0] mx [2];
    exp_t        q_a [$];
    exp_t        q_b [$];

    // ---------------- reference model ----------------
    function automatic logic [63:0] step(input logic [63:0] x);
        logic [63:0] a, b;
        a = x ^ (x << 13);
        b = a ^ (a >> 7);
        return b ^ (b << 17);
    endfunction

    function automatic logic [63:0] seed_fn(input logic [63:0] s, input int id);
        logic [63:0] m;
        m = s ^ (64'h9E3779B97F4A7C15 * 64'(id + 1));
        return (m == 64'd0) ? 64'd1 : m;
    endfunction

    // Draw one move: keep sampling positions until the rules accept them.
    task automatic model_draw(input logic [63:0] x_in, input int cn,
                              output logic [63:0] x_out, output logic mode,
                              output int k, output int l, output int rk, output int rl);
        logic [63:0] x;
        int c;
        bit ok;
        x = x_in; rk = 0; rl = 0; k = 0; c = 0;
        for (int it = 0; it < 10000; it++) begin
            x = step(x);
            c = int'(x[LOG-1:0]);
            if (c >= 1 && c <= cn - 1) break;
            rk++;
        end
        k = c;
        mode = x[63];
        for (int it = 0; it < 10000; it++) begin
            x = step(x);
            c = int'(x[LOG-1:0]);
            ok = (c >= 1) && (c <= cn - 1) && (c != k) && (mode || (c != k - 1));
            if (ok) break;
            rl++;
        end
        if (mode) begin
            l = (c > k) ? c : k;
            k = (c < k) ? c : k;
        end else begin
            l = c;
        end
        x_out = x;
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp_v);
        end
    endtask

    task automatic mon(input int d, input logic v, input logic rdy, input logic m,
                       input logic [LOG-1:0] k, input logic [LOG-1:0] l);
        exp_t e;
        int   lat, cn, ki, li;
        bit   have, ok;
        cn = (d == 0) ? N_A : N_B;
        if (hs_prev[d]) begin
            checks++;
            if (v) begin
                errors++;
                $display("FAIL valid_fall dut%0d: opt_valid=%0b required 0", d, v);
            end
        end
        if (v) begin
            have = (d == 0) ? (q_a.size() > 0) : (q_b.size() > 0);
            checks++;
            if (!have) begin
                errors++;
                $display("FAIL unexpected_valid dut%0d: opt_valid=1 required 0 (no request pending)", d);
            end else begin
                if (d == 0) e = q_a[0];
                else        e = q_b[0];
                if (!prev_valid[d]) begin
                    lat = cyc - req_edge[d] + 1;
                    checks++;
                    if (lat != e.lat) begin
                        errors++;
                        $display("FAIL latency dut%0d: got %0d required %0d", d, lat, e.lat);
                    end
                end
                checks++;
                if ({m, k, l} !== {e.mode, e.k, e.l}) begin
                    errors++;
                    $display("FAIL proposal dut%0d: got mode=%0b k=%0d l=%0d required mode=%0b k=%0d l=%0d",
                             d, m, k, l, e.mode, e.k, e.l);
                end
                if (rdy) begin
                    if (d == 0) void'(q_a.pop_front());
                    else        void'(q_b.pop_front());
                    hs_cnt[d]++;
                    ki = int'(k); li = int'(l);
                    if (m) ok = (ki >= 1) && (ki < li) && (li <= cn - 1);
                    else   ok = (ki >= 1) && (ki <= cn - 1) && (li >= 1) && (li <= cn - 1) &&
                                (ki != li) && (li != ki - 1);
                    checks++;
                    if (!ok) begin
                        errors++;
                        $display("FAIL move_rule dut%0d: got mode=%0b k=%0d l=%0d outside legal move set", d, m, k, l);
                    end
                end
            end
        end
        hs_prev[d]    = v && rdy;
        prev_valid[d] = v;
    endtask

    // Monitor samples mid-cycle, when DUT outputs and bench inputs are stable.
    always @(negedge clk) begin
        mon(0, bus_a.opt_valid, bus_a.opt_ready, bus_a.opt_mode, bus_a.opt_k, bus_a.opt_l);
        mon(1, bus_b.opt_valid, bus_b.opt_ready, bus_b.opt_mode, bus_b.opt_k, bus_b.opt_l);
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input int d, input logic v);
        if (d == 0) bus_a.opt_req = v;
        else        bus_b.opt_req = v;
    endtask

    task automatic set_rdy(input int d, input logic v);
        if (d == 0) bus_a.opt_ready = v;
        else        bus_b.opt_ready = v;
    endtask

    task automatic load_seed(input int d, input logic [63:0] s);
        if (d == 0) begin seed_a = s; init_a = 1'b1; end
        else        begin seed_b = s; init_b = 1'b1; end
        mx[d] = seed_fn(s, (d == 0) ? ID_A : ID_B);
        tick();
        init_a = 1'b0;
        init_b = 1'b0;
    endtask

    task automatic issue(input int d);
        exp_t        e;
        logic [63:0] xn;
        logic        mo;
        int          k, l, rk, rl;
        model_draw(mx[d], (d == 0) ? N_A : N_B, xn, mo, k, l, rk, rl);
        mx[d]  = xn;
        e.mode = mo;
        e.k    = k[LOG-1:0];
        e.l    = l[LOG-1:0];
        e.lat  = 3 + rk + rl;
        if (d == 0) q_a.push_back(e);
        else        q_b.push_back(e);
        req_edge[d] = cyc + 1;
        set_req(d, 1'b1);
        tick();
        set_req(d, 1'b0);
    endtask

    task automatic wait_hs(input int d, input int n0, input bit rnd);
        int  t;
        logic v;
        t = 0;
        while (hs_cnt[d] == n0 && t < 400) begin
            if (rnd) begin
                v = (d == 0) ? bus_a.opt_valid : bus_b.opt_valid;
                set_rdy(d, 1'($urandom_range(0, 1)));
                set_req(d, v ? 1'($urandom_range(0, 1)) : 1'b0);
            end
            tick();
            t++;
        end
        set_req(d, 1'b0);
        checks++;
        if (hs_cnt[d] == n0) begin
            errors++;
            $display("FAIL handshake_timeout dut%0d: got no handshake within %0d cycles", d, t);
            if (d == 0) q_a.delete();
            else        q_b.delete();
        end
    endtask

    task automatic request(input int d, input bit rnd);
        int n0;
        n0 = hs_cnt[d];
        issue(d);
        wait_hs(d, n0, rnd);
    endtask

    initial begin
        logic [63:0] xn;
        logic        mo;
        int          k, l, rk, rl, n0, t;

        reset = 1'b0;
        init_a = 1'b0; init_b = 1'b0; seed_a = '0; seed_b = '0;
        bus_a.opt_req = 1'b1; bus_a.opt_ready = 1'b0;
        bus_b.opt_req = 1'b1; bus_b.opt_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            hs_cnt[i] = 0; req_edge[i] = 0; prev_valid[i] = 1'b0; hs_prev[i] = 1'b0; mx[i] = 64'd1;
        end

        // Reset held with requests pending: everything stays at zero.
        repeat (2) begin
            tick();
            chk("reset_outputs_a", 64'({bus_a.opt_valid, bus_a.busy, bus_a.opt_mode, bus_a.opt_k, bus_a.opt_l}), 64'd0);
            chk("reset_outputs_b", 64'({bus_b.opt_valid, bus_b.busy, bus_b.opt_mode, bus_b.opt_k, bus_b.opt_l}), 64'd0);
        end
        reset = 1'b1;
        bus_a.opt_req = 1'b0;
        bus_b.opt_req = 1'b0;
        tick();

        // Seed that mixes to zero must fall back to a state of 1.
        set_rdy(0, 1'b1);
        load_seed(0, 64'h9E3779B97F4A7C15);
        repeat (4) request(0, 1'b0);

        // Long golden run with the consumer always ready.
        load_seed(0, 64'h0123456789ABCDEF);
        for (int i = 0; i < 1000; i++) request(0, 1'b0);

        // Backpressure: proposal held, extra requests ignored, x frozen.
        set_rdy(0, 1'b0);
        n0 = hs_cnt[0];
        issue(0);
        t = 0;
        while (!bus_a.opt_valid && t < 50) begin tick(); t++; end
        chk("bp_valid_up", 64'(bus_a.opt_valid), 64'd1);
        for (int i = 0; i < 20; i++) begin
            set_req(0, 1'($urandom_range(0, 1)));
            tick();
            chk("bp_busy", 64'(bus_a.busy), 64'd1);
        end
        set_req(0, 1'b0);
        chk("bp_no_handshake", 64'(hs_cnt[0]), 64'(n0));
        set_rdy(0, 1'b1);
        repeat (4) tick();
        chk("bp_single_handshake", 64'(hs_cnt[0]), 64'(n0 + 1));
        chk("bp_busy_after", 64'(bus_a.busy), 64'd0);
        repeat (3) request(0, 1'b0);

        // Abort in DRAW_L: reseed discards the draw, next request follows the fresh seed.
        model_draw(mx[0], N_A, xn, mo, k, l, rk, rl);
        set_req(0, 1'b1);
        tick();
        set_req(0, 1'b0);
        repeat (rk + 1) tick();
        chk("abort_busy_before", 64'(bus_a.busy), 64'd1);
        load_seed(0, 64'hDEADBEEFCAFEF00D);
        chk("abort_valid", 64'(bus_a.opt_valid), 64'd0);
        chk("abort_busy", 64'(bus_a.busy), 64'd0);
        repeat (3) request(0, 1'b0);

        // Request coinciding with reseed is dropped.
        set_req(0, 1'b1);
        load_seed(0, 64'h0F1E2D3C4B5A6978);
        set_req(0, 1'b0);
        chk("init_req_idle0", 64'(bus_a.busy), 64'd0);
        tick();
        chk("init_req_idle1", 64'(bus_a.busy), 64'd0);
        repeat (3) request(0, 1'b0);

        // 17 cities in a 5-bit index: frequent rejections, random consumer.
        load_seed(1, {32'($urandom), 32'($urandom)});
        for (int i = 0; i < 200; i++) request(1, 1'b1);
        set_rdy(1, 1'b1);
        tick();

        // Reset mid-draw returns both instances to the reset state.
        set_req(1, 1'b1);
        tick();
        set_req(1, 1'b0);
        tick();
        chk("mid_reset_busy_before", 64'(bus_b.busy), 64'd1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("mid_reset_outputs_b", 64'({bus_b.opt_valid, bus_b.busy, bus_b.opt_mode, bus_b.opt_k, bus_b.opt_l}), 64'd0);
        chk("mid_reset_outputs_a", 64'({bus_a.opt_valid, bus_a.busy, bus_a.opt_mode, bus_a.opt_k, bus_a.opt_l}), 64'd0);
        mx[0] = 64'd1;
        mx[1] = 64'd1;
        tick();
        chk("mid_reset_idle", 64'(bus_b.busy), 64'd0);
        repeat (2) request(1, 1'b0);
        load_seed(1, 64'h1122334455667788);
        repeat (5) request(1, 1'b0);
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/opt_gen.md
# opt_gen

Per-node move-proposal generator that sits directly upstream of each replica node. It owns the node's xorshift64 random state and draws a random 2-opt or or-opt move, with two city positions, under a valid/ready handshake. The node sequencer consumes the proposal as the `opt` input for one delta-distance / metropolis iteration. One instance is placed per replica, next to the node it feeds.

## Interface
- `id`, 0, replica index; used to decorrelate per-node seeds.
- `city_num`, 30, number of cities; position 0 is the fixed start city and is never proposed.
- `city_num_log`, 5, index width; requires 2**city_num_log >= city_num and city_num >= 4.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-low reset.
- `random_init`  in  1  one-cycle pulse; loads the seed.
- `random_seed`  in  64  global seed, sampled when random_init=1.
- `opt_req`  in  1  pulse; start drawing a proposal. Ignored unless IDLE.
- `opt_ready`  in  1  consumer accepts the proposal.
- `opt_valid`  out  1  proposal is held stable.
- `opt_mode`  out  1  0 = or-opt, 1 = 2-opt.
- `opt_k`  out  city_num_log  first position.
- `opt_l`  out  city_num_log  second position.
- `busy`  out  1  FSM is not IDLE.

## Operation
- State register x[63:0]. Step function: a = x^(x<<13); b = a^(b>>7 applied to a, i.e. b = a^(a>>7)); n = b^(b<<17). Shifts are logical and truncated to 64 bits.
- x advances only in DRAW_K and DRAW_L, exactly once per cycle in those states. This makes the draw sequence a pure function of the seed and the request count.
- Seeding: s = random_seed ^ (64'h9E3779B97F4A7C15 * (id+1)), truncated to 64 bits. If s == 0, load 1. x never holds 0.
- random_init has the highest priority after reset, in any state. It loads x, forces IDLE, and clears opt_valid. Any in-flight proposal is discarded.
- The candidate is c = n[city_num_log-1:0]. It is legal iff 1 <= c <= city_num-1; an illegal candidate is rejected.
- FSM states: IDLE, DRAW_K, DRAW_L, OUT.
  - IDLE --opt_req--> DRAW_K.
  - DRAW_K: on a legal c, latch k=c and mode=n[63], then go to DRAW_L. Otherwise stay.
  - DRAW_L: go to OUT when c is legal and passes the mode check. Otherwise stay.
    - 2-opt: c != k. Outputs are opt_k=min(k,c) and opt_l=max(k,c).
    - or-opt: c != k and c != k-1. Outputs are opt_k=k (city moved) and opt_l=c (insert after).
  - OUT: opt_valid=1. Go to IDLE on opt_ready.
- opt_mode, opt_k and opt_l are registered and change only on entry to OUT. They stay stable while opt_valid=1.
- Reset: x=1, state IDLE. All outputs are 0: opt_valid, opt_mode, opt_k, opt_l, busy.

## Timing
- opt_req sampled at edge t gives DRAW_K from t+1. With no rejections, OUT and opt_valid are first visible at t+3. Each rejection adds 1 cycle.
- Termination is guaranteed in expectation: with city_num >= 4, at least one legal L exists for every k.
- The handshake completes on a cycle where opt_valid && opt_ready. opt_valid falls on the next cycle.
- A new opt_req is honoured no earlier than the cycle after the return to IDLE. opt_req in the same cycle as the handshake is ignored.
- opt_req together with random_init: the seed is loaded, state stays IDLE, and the request is dropped.
- reset low mid-draw: next cycle matches the reset state exactly. The seed must be reloaded.
- busy = (state != IDLE), registered with the state.

## Test plan
- Reset: hold reset=0 for 2 cycles with opt_req=1 -> opt_valid=0, busy=0, opt_k=opt_l=0 throughout.
- Seed 0 corner: id=0, random_seed=64'h9E3779B97F4A7C15 (s=0) -> x loads 1. The first step from x=1 gives n=64'h40822041, and the bench checks the subsequent proposal against the reference model.
- Golden sequence: city_num=30, random_seed=64'h0123456789ABCDEF, 1000 requests with opt_ready tied to 1 -> mode/k/l match the C model bit-exactly. Additionally, every 2-opt has 1<=k<l<=29 and every or-opt has k!=l and l!=k-1.
- Rejection latency: city_num=17 with city_num_log=5 (about 50% rejects) -> each req-to-valid latency equals 3 + the model's rejection count.
- Backpressure: hold opt_ready=0 for 20 cycles while opt_valid=1 -> outputs are stable, x does not advance, and further opt_req pulses are ignored. opt_ready=1 gives a single handshake.
- Abort: random_init pulse in DRAW_L -> next cycle is IDLE with opt_valid=0. The next request reproduces the sequence of a fresh seed.
